// File: rtl/mips_mem_defs.sv
// Shared definitions for the instruction-side memory fill path: FSM
// encoding, line geometry and memory-bus field widths.
package mips_mem_defs;

    // Line geometry: four 32-bit words per line, 2-bit word offset.
    localparam int LINE_WORDS = 4;
    localparam int OFF_W      = 2;

    // Memory bus fields.
    localparam int BUS_DATA_W = 32;
    localparam int BEAT_W     = 2;
    localparam logic [BEAT_W-1:0] LAST_BEAT = 2'd3;

    // Fill engine states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } fill_state_e;

    // Which request input owns the transfer in flight.
    typedef enum logic {
        REQ_LINE = 1'b0,
        REQ_WORD = 1'b1
    } req_kind_e;

    // Word offset advances modulo the line length (2-bit natural wrap).
    function automatic logic [OFF_W-1:0] next_offset(input logic [OFF_W-1:0] off);
        return off + 1'b1;
    endfunction

endpackage

// File: rtl/icache_line_fill_unit.sv
// Memory-side fill engine for the instruction cache. Serves 4-word line
// fills and single-word reads one bus beat at a time and returns every word
// with its line offset and a one-cycle Ready_M pulse.
// Build option: ICACHE_CRITICAL_WORD_FIRST_EN makes a line fill start at the
// requested word and wrap; otherwise line fills always start at offset 0.
module icache_line_fill_unit
    import mips_mem_defs::*;
#(
    parameter int PABITS = 36
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [PABITS-3:0]     Address_M,
    input  logic                  ReadLine_M,
    input  logic                  ReadWord_M,
    output logic [BUS_DATA_W-1:0] DataIn_M,
    output logic [OFF_W-1:0]      DataInOffset_M,
    output logic                  Ready_M,
    output logic [PABITS-3:0]     Bus_Address,
    output logic                  Bus_Read,
    input  logic [BUS_DATA_W-1:0] Bus_DataIn,
    input  logic                  Bus_Ack,
    output logic                  Busy
);

    localparam int WA_W   = PABITS - 2;
    localparam int LINE_W = WA_W - OFF_W;

    fill_state_e             state_q, state_d;
    req_kind_e               kind_q, kind_d;
    logic [LINE_W-1:0]       line_q, line_d;
    logic [OFF_W-1:0]        off_q, off_d;
    logic [BEAT_W-1:0]       beats_q, beats_d;
    logic                    gap_q, gap_d;
    logic                    abort_q, abort_d;
    logic [BUS_DATA_W-1:0]   data_q, data_d;
    logic [OFF_W-1:0]        data_off_q, data_off_d;
    logic                    ready_q, ready_d;

    logic                    bus_read;
    logic                    req_held;
    logic                    accept;
    logic                    drop_beat;
    logic [OFF_W-1:0]        line_start;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    assign line_start = Address_M[OFF_W-1:0];
`else
    assign line_start = '0;
`endif

    // The strobe is a pure function of registered state, so an asynchronous
    // reset removes it in the same cycle. gap_q forces the idle beat between
    // consecutive reads.
    assign bus_read  = (state_q == ST_READ) && !gap_q;
    assign req_held  = (kind_q == REQ_LINE) ? ReadLine_M : ReadWord_M;
    assign accept    = bus_read && Bus_Ack;
    // A beat is thrown away once its owning request has been withdrawn.
    assign drop_beat = abort_q || !req_held;

    assign Bus_Read       = bus_read;
    assign Bus_Address    = bus_read ? {line_q, off_q} : '0;
    assign Busy           = (state_q != ST_IDLE);
    assign DataIn_M       = data_q;
    assign DataInOffset_M = data_off_q;
    assign Ready_M        = ready_q;

    // Next-state and return-path logic for the fill FSM.
    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d    = state_q;
        kind_d     = kind_q;
        line_d     = line_q;
        off_d      = off_q;
        beats_d    = beats_q;
        gap_d      = 1'b0;
        abort_d    = abort_q;
        data_d     = data_q;
        data_off_d = data_off_q;
        ready_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                abort_d = 1'b0;
                if (ReadLine_M) begin
                    // Line wins when both requests are present.
                    kind_d  = REQ_LINE;
                    line_d  = Address_M[WA_W-1:OFF_W];
                    off_d   = line_start;
                    beats_d = '0;
                    state_d = ST_READ;
                end else if (ReadWord_M) begin
                    // A single word is a one-beat transfer: start on the last beat.
                    kind_d  = REQ_WORD;
                    line_d  = Address_M[WA_W-1:OFF_W];
                    off_d   = Address_M[OFF_W-1:0];
                    beats_d = LAST_BEAT;
                    state_d = ST_READ;
                end
            end

            ST_READ: begin
                // Remember a withdrawn request even if it reappears later.
                if (!req_held) begin
                    abort_d = 1'b1;
                end
                if (accept) begin
                    if (!drop_beat) begin
                        data_d     = Bus_DataIn;
                        data_off_d = off_q;
                        ready_d    = 1'b1;
                    end
                    if (drop_beat || beats_q == LAST_BEAT) begin
                        beats_d = '0;
                        state_d = ST_DONE;
                    end else begin
                        beats_d = beats_q + 2'd1;
                        off_d   = next_offset(off_q);
                        gap_d   = 1'b1;
                    end
                end
            end

            ST_DONE: begin
                // Turnaround cycle: a request still high here is not a new one.
                abort_d = 1'b0;
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers, cleared asynchronously.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            kind_q     <= REQ_LINE;
            line_q     <= '0;
            off_q      <= '0;
            beats_q    <= '0;
            gap_q      <= 1'b0;
            abort_q    <= 1'b0;
            data_q     <= '0;
            data_off_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state_q    <= state_d;
            kind_q     <= kind_d;
            line_q     <= line_d;
            off_q      <= off_d;
            beats_q    <= beats_d;
            gap_q      <= gap_d;
            abort_q    <= abort_d;
            data_q     <= data_d;
            data_off_q <= data_off_d;
            ready_q    <= ready_d;
        end
    end

endmodule

// File: tb/tb_icache_line_fill_unit.sv
// Self-checking bench for icache_line_fill_unit: directed scenarios plus
// randomized requests against a memory model and an expected-beat model.
module tb_icache_line_fill_unit;

    localparam int WA_W = 34;

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic            clock;
    logic            reset;
    logic [WA_W-1:0] Address_M;
    logic            ReadLine_M;
    logic            ReadWord_M;
    logic [31:0]     DataIn_M;
    logic [1:0]      DataInOffset_M;
    logic            Ready_M;
    logic [WA_W-1:0] Bus_Address;
    logic            Bus_Read;
    logic [31:0]     Bus_DataIn;
    logic            Bus_Ack;
    logic            Busy;

    int total = 0;
    int bad   = 0;
    int ack_delay = 0;

    logic [31:0]     mem [logic [WA_W-1:0]];
    logic [WA_W-1:0] bus_q[$];
    logic [1:0]      exp_off_q[$];
    logic [WA_W-1:0] exp_addr_q[$];
    logic [31:0]     exp_data_q[$];

    icache_line_fill_unit #(.PABITS(36)) dut (
        .clock          (clock),
        .reset          (reset),
        .Address_M      (Address_M),
        .ReadLine_M     (ReadLine_M),
        .ReadWord_M     (ReadWord_M),
        .DataIn_M       (DataIn_M),
        .DataInOffset_M (DataInOffset_M),
        .Ready_M        (Ready_M),
        .Bus_Address    (Bus_Address),
        .Bus_Read       (Bus_Read),
        .Bus_DataIn     (Bus_DataIn),
        .Bus_Ack        (Bus_Ack),
        .Busy           (Busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [WA_W-1:0] a);
        if (!mem.exists(a)) mem[a] = $urandom;
        return mem[a];
    endfunction

    function automatic logic [WA_W-1:0] rand_addr();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[WA_W-1:0];
    endfunction

    // Reference model: the list of words a request must return, in order.
    task automatic build_expected(input logic [WA_W-1:0] addr, input logic line, input logic word);
        int n;
        int start;
        logic [WA_W-1:0] a;
        exp_off_q.delete();
        exp_addr_q.delete();
        exp_data_q.delete();
        n = line ? 4 : (word ? 1 : 0);
        start = (line && !CWF) ? 0 : int'(addr[1:0]);
        for (int i = 0; i < n; i++) begin
            a = {addr[WA_W-1:2], 2'(start + i)};
            exp_off_q.push_back(2'(start + i));
            exp_addr_q.push_back(a);
            exp_data_q.push_back(mem_word(a));
        end
    endtask

    // Memory responder: acks a pending read after ack_delay idle cycles.
    initial begin
        int wait_cnt;
        wait_cnt   = 0;
        Bus_Ack    = 1'b0;
        Bus_DataIn = '0;
        forever begin
            @(negedge clock);
            if (Bus_Ack || !Bus_Read) begin
                Bus_Ack  = 1'b0;
                wait_cnt = 0;
            end else if (wait_cnt >= ack_delay) begin
                Bus_Ack    = 1'b1;
                Bus_DataIn = mem_word(Bus_Address);
                bus_q.push_back(Bus_Address);
                wait_cnt   = 0;
            end else begin
                wait_cnt++;
            end
        end
    end

    // One complete request; called just after a falling edge.
    task automatic do_fill(input string name, input logic [WA_W-1:0] addr, input logic line,
                           input logic word, input int delay, input bit scramble);
        int n, seen, cyc, extra;
        logic [1:0]  got_off[$];
        logic [31:0] got_data[$];
        build_expected(addr, line, word);
        n = exp_off_q.size();
        bus_q.delete();
        ack_delay  = delay;
        Address_M  = addr;
        ReadLine_M = line;
        ReadWord_M = word;
        seen = 0;
        cyc  = 0;
        while (seen < n && cyc < 500) begin
            @(negedge clock);
            cyc++;
            if (scramble) Address_M = rand_addr();
            if (Ready_M) begin
                got_off.push_back(DataInOffset_M);
                got_data.push_back(DataIn_M);
                seen++;
            end
        end
        check({name, "_beats"}, seen, n);
        check({name, "_busy_in_done"}, Busy, 1'b1);
        // Request stays high through the turnaround cycle, then is released.
        ReadLine_M = 1'b0;
        ReadWord_M = 1'b0;
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            if (Ready_M || Bus_Read) extra++;
            if (i == 1) check({name, "_busy_low"}, Busy, 1'b0);
        end
        check({name, "_no_restart"}, extra, 0);
        for (int i = 0; i < seen && i < n; i++) begin
            check({name, "_off"}, got_off[i], exp_off_q[i]);
            check({name, "_data"}, got_data[i], exp_data_q[i]);
        end
        check({name, "_bus_reads"}, bus_q.size(), n);
        for (int i = 0; i < bus_q.size() && i < n; i++) begin
            check({name, "_bus_addr"}, bus_q[i], exp_addr_q[i]);
        end
    endtask

    initial begin
        logic [WA_W-1:0] a;
        int seen, cyc, kind, extra;
        logic [1:0]  first_off;
        logic [31:0] first_data;

        reset      = 1'b1;
        Address_M  = '0;
        ReadLine_M = 1'b0;
        ReadWord_M = 1'b0;

        a = {24'h314159, 10'h3a8};
        mem[a]         = 32'hf39acd22;
        mem[a + 34'd1] = 32'haaabbbcc;
        mem[a + 34'd2] = 32'hddf80c25;
        mem[a + 34'd3] = 32'hff00ff00;
        a = {24'h555557, 10'h332};
        mem[a] = 32'h71717171;

        // Reset state.
        repeat (2) @(negedge clock);
        check("rst_ready", Ready_M, 1'b0);
        check("rst_busread", Bus_Read, 1'b0);
        check("rst_busy", Busy, 1'b0);
        check("rst_data", DataIn_M, 32'h0);
        check("rst_off", DataInOffset_M, 2'd0);
        check("rst_busaddr", Bus_Address, '0);
        reset = 1'b0;
        @(negedge clock);

        // Line fill from a word-aligned address, slow memory.
        do_fill("line_basic", {24'h314159, 10'h3a8}, 1'b1, 1'b0, 3, 1'b0);
        // Line fill with requested offset 3: order depends on the build.
        do_fill("line_off3", {24'h271828, 10'h0ab}, 1'b1, 1'b0, 1, 1'b0);
        // Single uncached word.
        do_fill("word", {24'h555557, 10'h332}, 1'b0, 1'b1, 1, 1'b0);
        // Both requests: line wins; fastest memory.
        do_fill("both", {24'h0badf0, 10'h2c6}, 1'b1, 1'b1, 0, 1'b0);

        // Abort: withdraw the line request after the first returned word.
        a = {24'h123456, 10'h044};
        build_expected(a, 1'b1, 1'b0);
        bus_q.delete();
        ack_delay  = 2;
        Address_M  = a;
        ReadLine_M = 1'b1;
        seen = 0;
        cyc  = 0;
        first_off  = '0;
        first_data = '0;
        while (seen == 0 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (Ready_M) begin
                first_off  = DataInOffset_M;
                first_data = DataIn_M;
                seen++;
            end
        end
        check("abort_first_beat", seen, 1);
        ReadLine_M = 1'b0;
        extra = 0;
        cyc   = 0;
        do begin
            @(negedge clock);
            cyc++;
            if (Ready_M) extra++;
        end while (Busy && cyc < 200);
        check("abort_idle", Busy, 1'b0);
        check("abort_no_ready", extra, 0);
        check("abort_off", first_off, exp_off_q[0]);
        check("abort_data", first_data, exp_data_q[0]);
        check("abort_bus_reads", bus_q.size(), 2);
        if (bus_q.size() >= 2) check("abort_bus_addr2", bus_q[1], exp_addr_q[1]);
        do_fill("after_abort", rand_addr(), 1'b0, 1'b1, 1, 1'b0);

        // Reset while the second beat's bus read is pending.
        a = {24'hfedcba, 10'h1f7};
        ack_delay  = 3;
        Address_M  = a;
        ReadLine_M = 1'b1;
        seen = 0;
        cyc  = 0;
        while (seen == 0 && cyc < 200) begin
            @(negedge clock);
            cyc++;
            if (Ready_M) seen++;
        end
        check("rstmid_first_beat", seen, 1);
        cyc = 0;
        do begin
            @(negedge clock);
            cyc++;
        end while (!Bus_Read && cyc < 50);
        check("rstmid_busread_before", Bus_Read, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("rstmid_busread", Bus_Read, 1'b0);
        check("rstmid_ready", Ready_M, 1'b0);
        check("rstmid_busy", Busy, 1'b0);
        ReadLine_M = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        do_fill("after_reset", a, 1'b1, 1'b0, 1, 1'b0);

        // Randomized requests with the address changing during the fill.
        for (int t = 0; t < 12; t++) begin
            kind = $urandom_range(2, 0);
            do_fill("rand", rand_addr(), kind != 1, kind != 0, $urandom_range(4, 0), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
